// File: rtl/vin_framewriter.sv
// Video input frame writer: packs the Y8 word stream into fixed-length
// memory write bursts, double-buffered, swapping the front buffer per frame.
module vin_framewriter #(
    parameter int BURST_LEN = 16,
    parameter int ADDR_W    = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              v_vsync,
    input  logic [31:0]       v_pixel,
    input  logic              v_valid,
    output logic              v_ready,
    input  logic [ADDR_W-1:0] fb_base0,
    input  logic [ADDR_W-1:0] fb_base1,
    input  logic [ADDR_W-1:0] frame_words,
    output logic              wr_cmd_valid,
    input  logic              wr_cmd_ready,
    output logic [ADDR_W-1:0] wr_cmd_addr,
    output logic [31:0]       wr_data,
    output logic              wr_data_valid,
    input  logic              wr_data_ready,
    output logic              wr_data_last,
    output logic              front_buf,
    output logic              frame_done,
    output logic              frame_abort
);

    localparam int BC_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_DATA,
        S_DONE,
        S_PAD
    } state_t;

    state_t            state_q, state_d;
    logic              vsync_q;
    logic [ADDR_W-1:0] fl_q, fl_d;
    logic              wb_q, wb_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] wc_q, wc_d;
    logic [BC_W-1:0]   bc_q, bc_d;
    logic              front_q, front_d;
    logic              abort_q, abort_d;
    logic              armed_q, armed_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;

    logic vs_edge;
    logic last_bc;
    logic cmd_hs;
    logic data_beat;
    logic frame_end;
    logic completing;

    assign vs_edge   = v_vsync & ~vsync_q;
    assign last_bc   = (bc_q == BC_W'(BURST_LEN - 1));
    assign cmd_hs    = (state_q == S_CMD) & wr_cmd_ready;
    assign data_beat = ((state_q == S_DATA) & v_valid & wr_data_ready)
                     | ((state_q == S_PAD) & wr_data_ready);
    assign frame_end = (state_q == S_DATA) & data_beat & last_bc
                     & ((wc_q + ADDR_W'(1)) == fl_q);
    // A frame finishing this cycle means the write buffer flips for the next one
    assign completing = frame_end | (state_q == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            vsync_q    <= 1'b0;
            fl_q       <= '0;
            wb_q       <= 1'b0;
            base_q     <= '0;
            wc_q       <= '0;
            bc_q       <= '0;
            front_q    <= 1'b0;
            abort_q    <= 1'b0;
            armed_q    <= 1'b0;
            cmd_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            vsync_q    <= v_vsync;
            fl_q       <= fl_d;
            wb_q       <= wb_d;
            base_q     <= base_d;
            wc_q       <= wc_d;
            bc_q       <= bc_d;
            front_q    <= front_d;
            abort_q    <= abort_d;
            armed_q    <= armed_d;
            cmd_addr_q <= cmd_addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fl_d    = fl_q;
        wb_d    = wb_q;
        base_d  = base_q;
        wc_d    = wc_q;
        bc_d    = bc_q;
        front_d = front_q;
        abort_d = 1'b0;
        armed_d = armed_q;

        if (data_beat) begin
            bc_d = bc_q + BC_W'(1);
            if (state_q == S_DATA) begin
                wc_d = wc_q + ADDR_W'(1);
            end
        end

        if (vs_edge) begin
            fl_d   = frame_words & ~ADDR_W'(BURST_LEN - 1);
            wb_d   = completing ? ~wb_q : ~front_q;
            base_d = wb_d ? fb_base1 : fb_base0;
            wc_d   = '0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (vs_edge && fl_d != '0) begin
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                if (cmd_hs) begin
                    bc_d    = '0;
                    state_d = vs_edge ? S_PAD : S_DATA;
                end else if (vs_edge) begin
                    abort_d = 1'b1;
                    state_d = (fl_d != '0) ? S_CMD : S_IDLE;
                end
            end
            S_DATA: begin
                if (data_beat && last_bc) begin
                    if (frame_end) begin
                        state_d = S_DONE;
                        armed_d = vs_edge;
                    end else if (vs_edge) begin
                        abort_d = 1'b1;
                        state_d = (fl_d != '0) ? S_CMD : S_IDLE;
                    end else begin
                        state_d = S_CMD;
                    end
                end else if (vs_edge) begin
                    state_d = S_PAD;
                end
            end
            S_PAD: begin
                if (data_beat && last_bc) begin
                    abort_d = 1'b1;
                    state_d = (fl_d != '0) ? S_CMD : S_IDLE;
                end
            end
            S_DONE: begin
                front_d = wb_q;
                armed_d = 1'b0;
                if ((armed_q || vs_edge) && fl_d != '0) begin
                    state_d = S_CMD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        cmd_addr_d = base_d + wc_d;
    end

    always_comb begin
        v_ready       = 1'b0;
        wr_cmd_valid  = 1'b0;
        wr_data       = '0;
        wr_data_valid = 1'b0;
        wr_data_last  = 1'b0;
        frame_done    = 1'b0;
        unique case (state_q)
            S_IDLE: v_ready = 1'b1;
            S_CMD:  wr_cmd_valid = 1'b1;
            S_DATA: begin
                wr_data       = v_pixel;
                wr_data_valid = v_valid;
                v_ready       = wr_data_ready;
                wr_data_last  = last_bc;
            end
            S_PAD: begin
                wr_data_valid = 1'b1;
                wr_data_last  = last_bc;
            end
            S_DONE: frame_done = 1'b1;
            default: ;
        endcase
        if (rst) begin
            v_ready       = 1'b0;
            wr_cmd_valid  = 1'b0;
            wr_data_valid = 1'b0;
            wr_data_last  = 1'b0;
            frame_done    = 1'b0;
        end
    end

    assign wr_cmd_addr = cmd_addr_q;
    assign front_buf   = front_q;
    assign frame_abort = abort_q & ~rst;

endmodule
